// File: rtl/cycle_computer_pkg.sv
// rtl/cycle_computer_pkg.sv - shared types and constants for the cycle-computer key path
package cycle_computer_pkg;

  // Per-channel key classification states
  typedef enum logic [1:0] {
    WAIT_RELEASE = 2'd0,
    IDLE         = 2'd1,
    PRESSED      = 2'd2,
    LONG_HELD    = 2'd3
  } key_state_t;

  // Channel index of each board key
  localparam int KEY_MODE = 0;
  localparam int KEY_TRIP = 1;

  // Default timing at a 50 MHz system clock
  localparam int DEBOUNCE_2MS_50M = 100000;
  localparam int LONG_1S_50M      = 50000000;

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one key: synchroniser, debouncer, short/long press classifier
module key_channel
  import cycle_computer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_2MS_50M,
  parameter int LONG_CYCLES     = LONG_1S_50M
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic nkey_i,
  output logic key_down_o,
  output logic short_press_o,
  output logic long_press_o
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_TOP = HW'(LONG_CYCLES);

  logic          sync1_q;
  logic          sync2_q;
  logic [1:0]    fill_q;
  logic          raw_down;

  logic          deb_down_q, deb_down_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;

  key_state_t    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          short_q, short_d;
  logic          long_q, long_d;

  // Two-flop synchroniser, preset to "released"; fill_q marks when both flops
  // hold real pin samples rather than their reset preset, so a key held through
  // reset cannot be mistaken for a released one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fill_q  <= 2'b00;
    end else begin
      sync1_q <= nkey_i;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
    end
  end

  assign raw_down = ~sync2_q;

  // Debounce: count consecutive disagreeing cycles, flip after a full run
  always_comb begin
    deb_down_d = deb_down_q;
    deb_cnt_d  = '0;
    if (raw_down != deb_down_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_down_d = raw_down;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  // Debounced level and run counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      deb_down_q <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      deb_down_q <= deb_down_d;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  // Press classifier: next state, hold count and pulse requests
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      WAIT_RELEASE: begin
        if (fill_q[1] && !deb_down_q && !raw_down) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (deb_down_q) begin
          state_d = PRESSED;
          hold_d  = '0;
        end
      end
      PRESSED: begin
        if (!deb_down_q) begin
          // A release on the same cycle the hold would turn long stays short.
          short_d = 1'b1;
          state_d = IDLE;
        end else begin
          if (hold_q != HOLD_TOP) begin
            hold_d = hold_q + HW'(1);
          end
          if (hold_d == HOLD_TOP) begin
            long_d  = 1'b1;
            state_d = LONG_HELD;
          end
        end
      end
      LONG_HELD: begin
        if (!deb_down_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = WAIT_RELEASE;
      end
    endcase
  end

  // Classifier state, hold counter and registered one-cycle pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WAIT_RELEASE;
      hold_q  <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      short_q <= short_d;
      long_q  <= long_d;
    end
  end

  assign key_down_o    = (state_q == PRESSED) || (state_q == LONG_HELD);
  assign short_press_o = short_q;
  assign long_press_o  = long_q;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - conditions the active-low board keys into press pulses
module key_conditioner
  import cycle_computer_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_2MS_50M,
  parameter int LONG_CYCLES     = LONG_1S_50M
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] nKEY,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] short_press,
  output logic [NUM_KEYS-1:0] long_press,
  output logic                any_activity
);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
    ) u_channel (
      .clk_i         (CLK),
      .rst_i         (RESET),
      .nkey_i        (nKEY[k]),
      .key_down_o    (key_down[k]),
      .short_press_o (short_press[k]),
      .long_press_o  (long_press[k])
    );
  end

  assign any_activity = |(short_press | long_press);

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - randomized and directed self-checking bench for key_conditioner
module tb_key_conditioner;

  localparam int DEB = 8;
  localparam int LNG = 64;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] nKEY = 2'b11;
  logic [1:0] key_down, short_press, long_press;
  logic       any_activity;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  key_conditioner #(
    .NUM_KEYS        (2),
    .DEBOUNCE_CYCLES (DEB),
    .LONG_CYCLES     (LNG)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .nKEY         (nKEY),
    .key_down     (key_down),
    .short_press  (short_press),
    .long_press   (long_press),
    .any_activity (any_activity)
  );

  always #10 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pin samples reach the logic two edges late; the debounced
  // level flips after DEB consecutive opposing samples; a press is classified by
  // how long the debounced hold lasted, measured in edges since key_down rose.
  bit         m_p1 [2];
  bit         m_p2 [2];
  bit         m_win [2][DEB];
  int         m_nwin [2];
  bit         m_deb [2];
  bit         m_armed [2];
  bit         m_kd [2];
  bit         m_long_done [2];
  int         m_rise [2];
  int         m_edges = 0;
  int         m_cyc = 0;
  logic [1:0] e_kd = 2'b00;
  logic [1:0] e_short = 2'b00;
  logic [1:0] e_long = 2'b00;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_edges = 0;
      e_kd = 2'b00;
      e_short = 2'b00;
      e_long = 2'b00;
      for (int k = 0; k < 2; k++) begin
        m_p1[k] = 1'b1;
        m_p2[k] = 1'b1;
        m_nwin[k] = 0;
        m_deb[k] = 1'b0;
        m_armed[k] = 1'b0;
        m_kd[k] = 1'b0;
        m_long_done[k] = 1'b0;
      end
    end else begin
      m_edges++;
      m_cyc++;
      e_short = 2'b00;
      e_long = 2'b00;
      for (int k = 0; k < 2; k++) begin
        bit sd;
        bit db;
        bit opp;
        sd = !m_p2[k];
        db = m_deb[k];
        m_p2[k] = m_p1[k];
        m_p1[k] = nKEY[k];
        for (int i = DEB - 1; i > 0; i--) m_win[k][i] = m_win[k][i-1];
        m_win[k][0] = sd;
        if (m_nwin[k] < DEB) m_nwin[k]++;
        opp = (m_nwin[k] == DEB);
        for (int i = 0; i < DEB; i++) if (m_win[k][i] == db) opp = 1'b0;
        if (opp) m_deb[k] = !db;
        if (!m_armed[k]) begin
          if (m_edges >= 3 && !db && !sd) m_armed[k] = 1'b1;
        end else if (!m_kd[k] && db) begin
          m_kd[k] = 1'b1;
          m_rise[k] = m_cyc;
          m_long_done[k] = 1'b0;
        end else if (m_kd[k] && !db) begin
          m_kd[k] = 1'b0;
          if (!m_long_done[k]) e_short[k] = 1'b1;
        end else if (m_kd[k] && !m_long_done[k] && (m_cyc - m_rise[k]) == LNG) begin
          e_long[k] = 1'b1;
          m_long_done[k] = 1'b1;
        end
        e_kd[k] = m_kd[k];
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge CLK) begin
    if (chk_en) begin
      check("key_down", key_down, e_kd);
      check("short_press", short_press, e_short);
      check("long_press", long_press, e_long);
      check("any_activity", any_activity, |(e_short | e_long));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_down(input int k, output int n);
    n = 0;
    @(negedge CLK);
    while (!key_down[k] && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (!key_down[k]) n = -1;
  endtask

  task automatic observe(input int n, output int ns0, output int nl0, output int nkd0,
                         output int ns1, output int nkd1, output int nboth, output int nact);
    ns0 = 0; nl0 = 0; nkd0 = 0; ns1 = 0; nkd1 = 0; nboth = 0; nact = 0;
    repeat (n) begin
      @(negedge CLK);
      ns0 += int'(short_press[0]);
      nl0 += int'(long_press[0]);
      nkd0 += int'(key_down[0]);
      ns1 += int'(short_press[1] | long_press[1]);
      nkd1 += int'(key_down[1]);
      nboth += int'(short_press == 2'b11);
      nact += int'(any_activity);
      if (short_press[0]) check("short_at_fall", key_down[0], 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n, ns0, nl0, nkd0, ns1, nkd1, nboth, nact;
    int rem [2];

    RESET = 1'b1;
    nKEY = 2'b11;
    cycles(3);
    check("reset_key_down", key_down, 2'b00);
    check("reset_pulses", {short_press, long_press, any_activity}, 5'd0);
    RESET = 1'b0;
    chk_en = 1'b1;
    cycles(5);

    // Clean short press on Mode
    nKEY[0] = 1'b0;
    wait_down(0, n);
    check("press_latency", n, 10);
    cycles(9);
    nKEY[0] = 1'b1;
    observe(30, ns0, nl0, nkd0, ns1, nkd1, nboth, nact);
    check("short_count", ns0, 1);
    check("short_no_long", nl0, 0);

    // Glitchy Trip never accepted
    nKEY[1] = 1'b0; cycles(5);
    nKEY[1] = 1'b1; cycles(3);
    nKEY[1] = 1'b0; cycles(5);
    nKEY[1] = 1'b1;
    observe(30, ns0, nl0, nkd0, ns1, nkd1, nboth, nact);
    check("glitch_key_down", nkd1, 0);
    check("glitch_pulses", ns1, 0);

    // Long hold on Mode
    nKEY[0] = 1'b0;
    wait_down(0, n);
    n = 0;
    while (!long_press[0] && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check("long_latency", n, LNG);
    cycles(25);
    nKEY[0] = 1'b1;
    observe(30, ns0, nl0, nkd0, ns1, nkd1, nboth, nact);
    check("long_release_short", ns0, 0);
    check("long_release_long", nl0, 0);

    // Key held through reset is ignored until let go
    nKEY[0] = 1'b0;
    RESET = 1'b1;
    cycles(3);
    RESET = 1'b0;
    observe(200, ns0, nl0, nkd0, ns1, nkd1, nboth, nact);
    check("held_reset_kd", nkd0, 0);
    check("held_reset_pulses", ns0 + nl0, 0);
    nKEY[0] = 1'b1;
    observe(30, ns0, nl0, nkd0, ns1, nkd1, nboth, nact);
    check("held_release_kd", nkd0, 0);
    check("held_release_short", ns0, 0);
    nKEY[0] = 1'b0;
    cycles(20);
    nKEY[0] = 1'b1;
    observe(30, ns0, nl0, nkd0, ns1, nkd1, nboth, nact);
    check("after_held_short", ns0, 1);

    // Both keys together
    nKEY = 2'b00;
    cycles(20);
    nKEY = 2'b11;
    observe(30, ns0, nl0, nkd0, ns1, nkd1, nboth, nact);
    check("both_short", nboth, 1);
    check("both_activity", nact, 1);

    // Asynchronous reset mid-hold
    nKEY[0] = 1'b0;
    wait_down(0, n);
    cycles(30);
    #3 RESET = 1'b1;
    #1 check("async_key_down", key_down[0], 1'b0);
    cycles(3);
    RESET = 1'b0;
    observe(50, ns0, nl0, nkd0, ns1, nkd1, nboth, nact);
    check("post_reset_kd", nkd0, 0);
    check("post_reset_pulses", ns0 + nl0, 0);
    nKEY[0] = 1'b1;
    observe(30, ns0, nl0, nkd0, ns1, nkd1, nboth, nact);
    check("post_reset_release", ns0 + nl0 + nkd0, 0);
    nKEY[0] = 1'b0;
    cycles(20);
    nKEY[0] = 1'b1;
    observe(30, ns0, nl0, nkd0, ns1, nkd1, nboth, nact);
    check("post_reset_repress", ns0, 1);

    // Randomized key activity against the model
    rem[0] = 5;
    rem[1] = 17;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (rem[k] == 0) begin
          nKEY[k] = ~nKEY[k];
          case ($urandom_range(0, 2))
            0: rem[k] = int'($urandom_range(1, 9));
            1: rem[k] = int'($urandom_range(10, 40));
            default: rem[k] = int'($urandom_range(60, 110));
          endcase
        end else begin
          rem[k]--;
        end
      end
      if (c == 1500) RESET = 1'b1;
      if (c == 1503) RESET = 1'b0;
      @(negedge CLK);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Conditions the raw active-low push-buttons (Mode, Trip) before they reach the cycle-computer core.
- Per key: synchronises to CLK, debounces, and classifies each press as short or long.
- Emits single-cycle pulses the core consumes directly.
- Sits between the board keys and the processor's button peripheral.

Parameters:
- NUM_KEYS, 2, number of independent key channels (index 0 = Mode, 1 = Trip).
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles needed to accept a level change (2 ms at 50 MHz).
- LONG_CYCLES, 50000000, cycles the debounced key must stay down to count as a long press (1 s at 50 MHz).

Ports:
- CLK  input  1  system clock, 50 MHz.
- RESET  input  1  asynchronous, active-high reset.
- nKEY  input  NUM_KEYS  raw key inputs, active-low, asynchronous to CLK.
- key_down  output  NUM_KEYS  debounced level, 1 = held.
- short_press  output  NUM_KEYS  one-cycle pulse when a key is released before LONG_CYCLES.
- long_press  output  NUM_KEYS  one-cycle pulse when the hold reaches LONG_CYCLES.
- any_activity  output  1  OR of all short_press and long_press pulses, same cycle.

Behaviour:
- Reset:
  - All outputs 0.
  - Synchroniser flops preset to 1 (released); debounce counters 0.
  - Every channel FSM enters WAIT_RELEASE.
- Synchroniser: 2 flops per key; every later stage uses only the second flop.
- Debounce:
  - A counter increments while the synced value differs from the debounced state, and clears to 0 on any cycle it matches.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch, the debounced state flips and the counter clears.
  - Latency: a clean press sampled low at edge N gives key_down=1 at edge N+2+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES produces no output change.
- Counter widths:
  - Debounce counter: $clog2(DEBOUNCE_CYCLES).
  - Hold counter: $clog2(LONG_CYCLES+1).
  - Hold counter saturates and never wraps.
- Per-channel FSM states:
  - WAIT_RELEASE:
    - key_down held 0; no pulses are generated.
    - Leaves to IDLE once the debounced state has been "released" for one cycle.
    - Effect: a key held through reset deassertion is ignored until it has been let go.
  - IDLE:
    - Debounced press → PRESSED; key_down=1; hold counter cleared.
  - PRESSED:
    - Hold counter increments every cycle.
    - Debounced release before the count reaches LONG_CYCLES → short_press=1 for exactly one cycle, in the same cycle key_down falls; → IDLE.
    - Count reaches LONG_CYCLES → long_press=1 for one cycle, LONG_CYCLES cycles after key_down rose; → LONG_HELD.
  - LONG_HELD:
    - key_down stays 1.
    - Debounced release → key_down=0, no pulse; → IDLE.
- Release coinciding with the count reaching LONG_CYCLES: release wins. short_press fires, long_press does not.
- Channels are fully independent. Pulses on different channels may coincide in the same cycle; any_activity is then 1 for that single cycle.
- Asynchronous RESET mid-press: outputs drop immediately; the channel re-enters WAIT_RELEASE.
- No pulse is ever longer than one cycle, and short_press/long_press are never both 1 on the same channel.

Decomposition:
- Shared package cycle_computer_pkg:
  - key_state_t enum {WAIT_RELEASE, IDLE, PRESSED, LONG_HELD}.
  - Index constants KEY_MODE=0, KEY_TRIP=1.
  - Default cycle constants DEBOUNCE_2MS_50M=100000 and LONG_1S_50M=50000000.
- Sub-module key_channel:
  - Contains synchroniser, debounce counter, FSM and hold counter for one key.
  - key_conditioner instantiates it NUM_KEYS times via generate and forms any_activity.

Test Plan (bench uses DEBOUNCE_CYCLES=8, LONG_CYCLES=64, 20 ns clock):
- Reset with both keys released (nKEY=2'b11), deassert RESET, drop nKEY[0] to 0 at edge N, hold 20 cycles, release → key_down[0]=1 at edge N+10; short_press[0] one cycle at the key_down fall; long_press stays 0.
- nKEY[1] low for 5 cycles, high for 3, low for 5 → key_down[1] never rises; no pulses.
- Hold nKEY[0] low for 100 cycles → long_press[0] one cycle exactly 64 cycles after key_down rose; on release key_down falls and short_press stays 0.
- nKEY[0] held low while RESET deasserts, kept low 200 cycles, then released → no key_down, short_press or long_press; a following 20-cycle press gives a normal short_press.
- Both keys pressed at the same edge for 20 cycles, released together → short_press=2'b11 in the same cycle and any_activity=1 for one cycle.
- Assert RESET mid-hold at 30 cycles into PRESSED → key_down=0 asynchronously; after reset drops with the key still down, no pulses until release and a re-press.
